// File: rtl/pipe_div_unit.sv
// Iterative restoring divider for the E stage: quotient to LO, remainder to HI; 34-cycle start-to-restart.
// Latency: accepted start edge = cycle 0, busy cycles 1..WIDTH, done pulse in cycle WIDTH+1; stall holds D/E meanwhile.
// Backpressure: stall is raised combinationally while a request is being accepted or computed; cancel aborts silently.
module pipe_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             cancel,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             div_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] prem;
   logic [WIDTH-1:0] quo;
   logic             q_neg;
   logic             r_neg;
   logic             dvs_zero;

   logic             accept;
   logic             last_step;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             fits;
   logic [WIDTH-1:0] step_prem;
   logic [WIDTH-1:0] step_quo;

   assign accept    = (state == IDLE) && start && !cancel;
   assign last_step = (cnt == LAST_STEP);
   assign stall     = accept || (state == CALC);
   assign busy      = (state == CALC);

   // One restoring step: bring in the next dividend bit, keep the difference if it did not borrow.
   assign shifted   = {prem, dvd[WIDTH-1]};
   assign trial     = shifted - {1'b0, dvs};
   assign fits      = !trial[WIDTH];
   assign step_prem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign step_quo  = {quo[WIDTH-2:0], fits};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (cancel) begin
               state_nxt = IDLE;
            end else if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         prem     <= '0;
         quo      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         dvs_zero <= 1'b0;
         done     <= 1'b0;
         q        <= '0;
         r        <= '0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  dvd      <= (sign && dividend[WIDTH-1]) ? -dividend : dividend;
                  dvs      <= (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
                  prem     <= '0;
                  quo      <= '0;
                  cnt      <= '0;
                  q_neg    <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg    <= sign && dividend[WIDTH-1];
                  dvs_zero <= (divisor == '0);
               end
            end
            CALC: begin
               if (!cancel) begin
                  prem <= step_prem;
                  quo  <= step_quo;
                  dvd  <= {dvd[WIDTH-2:0], 1'b0};
                  cnt  <= cnt + CNT_W'(1);
                  if (last_step) begin
                     // Results land on the edge into DONE so they are valid during the done pulse.
                     // A zero divisor leaves |dividend| in prem, so the sign fix restores the raw dividend.
                     done     <= 1'b1;
                     q        <= dvs_zero ? '1 : (q_neg ? -step_quo : step_quo);
                     r        <= r_neg ? -step_prem : step_prem;
                     div_zero <= dvs_zero;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_div_unit.sv
// Randomized and directed checks of pipe_div_unit against a plain-arithmetic division model.
module tb_pipe_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sign;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        cancel;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] q;
   logic [31:0] r;
   logic        div_zero;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_q;
   logic [31:0] last_r;

   always #5 clk = ~clk;

   pipe_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sign     (sign),
      .dividend (dividend),
      .divisor  (divisor),
      .cancel   (cancel),
      .stall    (stall),
      .busy     (busy),
      .done     (done),
      .q        (q),
      .r        (r),
      .div_zero (div_zero)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] eq, output logic [31:0] er);
      if (b == 32'd0) begin
         eq = 32'hFFFF_FFFF;
         er = a;
      end else if (!s) begin
         eq = a / b;
         er = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         eq = 32'h8000_0000;
         er = 32'd0;
      end else begin
         eq = $signed(a) / $signed(b);
         er = $signed(a) % $signed(b);
      end
   endfunction

   // Runs one division from IDLE; returns in the done cycle. Operands are scrambled during CALC.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input bit hold);
      logic [31:0] eq;
      logic [31:0] er;
      int n;
      int st;
      model(a, b, s, eq, er);
      dividend = a;
      divisor  = b;
      sign     = s;
      cancel   = 1'b0;
      start    = 1'b1;
      #1;
      check32({tag, "/stall_req"}, stall, 1);
      st = 1;
      tick();
      n = 1;
      if (!hold) start = 1'b0;
      while (!done && n < 40) begin
         if (stall) st++;
         dividend = $urandom;
         divisor  = $urandom;
         sign     = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check32({tag, "/done_cycle"}, n, 33);
      check32({tag, "/stall_cycles"}, st, 33);
      check32({tag, "/q"}, q, eq);
      check32({tag, "/r"}, r, er);
      check32({tag, "/div_zero"}, div_zero, (b == 32'd0) ? 1 : 0);
      check32({tag, "/stall_in_done"}, stall, 0);
      last_q = eq;
      last_r = er;
      if (!hold) begin
         tick();
         check32({tag, "/done_pulse"}, done, 0);
         check32({tag, "/q_hold"}, q, eq);
         check32({tag, "/r_hold"}, r, er);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int n;

      rst = 1'b1; start = 1'b0; sign = 1'b0; cancel = 1'b0;
      dividend = '0; divisor = '0;
      last_q = '0; last_r = '0;
      tick();
      tick();
      check32("rst/busy", busy, 0);
      check32("rst/done", done, 0);
      check32("rst/q", q, 0);
      check32("rst/r", r, 0);
      check32("rst/div_zero", div_zero, 0);
      check32("rst/stall", stall, 0);
      rst = 1'b0;
      tick();

      // start together with cancel is not accepted
      start = 1'b1; cancel = 1'b1; dividend = 32'd100; divisor = 32'd7;
      #1;
      check32("startcancel/stall", stall, 0);
      tick();
      check32("startcancel/busy", busy, 0);
      start = 1'b0; cancel = 1'b0;
      tick();

      run_div("u100_7",   32'd100,        32'd7,          1'b0, 1'b0);
      run_div("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0);
      run_div("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0);
      run_div("s_dz",     32'h1234_5678,  32'd0,          1'b1, 1'b0);
      run_div("u_dz",     32'h1234_5678,  32'd0,          1'b0, 1'b0);
      run_div("s_dzneg",  32'h8000_0000,  32'd0,          1'b1, 1'b0);
      run_div("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0);
      run_div("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0);

      // cancel at cycle 10: no done, results untouched
      dividend = 32'd100; divisor = 32'd7; sign = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check32("cancel/busy", busy, 0);
      check32("cancel/done", done, 0);
      n = 0;
      repeat (30) begin
         if (done) n++;
         tick();
      end
      check32("cancel/no_done", n, 0);
      check32("cancel/q_kept", q, last_q);
      check32("cancel/r_kept", r, last_r);
      run_div("after_cancel", 32'd100, 32'd7, 1'b0, 1'b0);

      // rst at cycle 20 clears everything
      dividend = 32'd1000; divisor = 32'd9; sign = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check32("midrst/busy", busy, 0);
      check32("midrst/done", done, 0);
      check32("midrst/q", q, 0);
      check32("midrst/r", r, 0);
      check32("midrst/div_zero", div_zero, 0);
      check32("midrst/stall", stall, 0);
      tick();

      // start held through DONE: one pulse, then a fresh division from IDLE
      run_div("hold", 32'd1000, 32'd3, 1'b0, 1'b1);
      dividend = 32'd1000; divisor = 32'd3; sign = 1'b0;
      tick();
      check32("hold/done_once", done, 0);
      check32("hold/idle_stall", stall, 1);
      tick();
      check32("hold/restart_busy", busy, 1);
      start = 1'b0;
      n = 1;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check32("hold/second_cycle", n, 33);
      check32("hold/second_q", q, 32'd333);
      check32("hold/second_r", r, 32'd1);
      tick();

      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 20));
            2:       b = $urandom >> $urandom_range(0, 31);
            default: b = -32'($urandom_range(1, 1000));
         endcase
         run_div($sformatf("rnd%0d", i), a, b, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_div_unit.md
Name: pipe_div_unit

Overview:
- Iterative 32-bit divider for the execute stage of the static pipeline CPU.
- Consumes the E-stage divide controls and operands: start from Ediv, signedness from Esign, operands from Ea and Eb.
- Produces quotient (LO) and remainder (HI) for the HI/LO write path.
- Raises a stall request so the D/E and earlier stages freeze while the division runs.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, width of the iteration counter; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  divide request from the E stage (Ediv).
- sign  input  1  1 = signed division, 0 = unsigned (Esign).
- dividend  input  WIDTH  dividend (Ea).
- divisor  input  WIDTH  divisor (Eb).
- cancel  input  1  flush from exception/branch logic; aborts the current division.
- stall  output  1  combinational: (state==IDLE & start & ~cancel) | (state==CALC).
- busy  output  1  registered: state==CALC.
- done  output  1  one-cycle pulse; q and r are valid and updated.
- q  output  WIDTH  quotient, destined for LO.
- r  output  WIDTH  remainder, destined for HI.
- div_zero  output  1  set with done when the divisor was 0.

Behaviour:
- Reset and clocking: one clock. Reset is synchronous and active-high on rst. rst has priority over all other inputs.
- Reset values: state=IDLE, counter=0, busy=0, done=0, q=0, r=0, div_zero=0. rst asserted mid-CALC discards the division and returns to IDLE on the next edge.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and cancel=0 at a clock edge: latch |dividend| and |divisor| (absolute values only when sign=1). Also latch the quotient sign (sign & (dividend[31]^divisor[31])) and remainder sign (sign & dividend[31]). Clear the partial remainder and counter, then go to CALC.
  - Otherwise stay in IDLE.
- CALC: one restoring shift/subtract step per cycle, MSB first.
  - Partial remainder is WIDTH+1 bits. Each step shifts it left and takes the next dividend bit in, then trial-subtracts the divisor.
  - If the result is non-negative: keep it and shift 1 into the quotient. Otherwise shift 0.
  - The counter increments each step. After step WIDTH (counter reaches WIDTH), go to DONE.
  - cancel=1 in CALC: go to IDLE next edge; q, r and div_zero are left unchanged and no done pulse occurs.
- DONE, one cycle:
  - done=1. q and r are registered with sign correction: negate q if the quotient sign is set; negate r if the remainder sign is set.
  - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Return to IDLE unconditionally. start is ignored in DONE, so an instruction still held in E is not restarted. The pipeline advances during the DONE cycle (stall=0).
- Latency: the start edge is cycle 0. busy is high for cycles 1..32, done is high in cycle 33, and q/r are valid from cycle 33. A new start is accepted from cycle 34.
- stall is high from the cycle start is presented in IDLE through the last CALC cycle (33 cycles total).
- Divide by zero:
  - q=32'hFFFFFFFF and r=dividend, unmodified, in both signed and unsigned modes.
  - div_zero=1 while done=1. Latency is unchanged.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0, with no flag.
- Outputs q, r and div_zero hold their values until the next done or rst.
- start and cancel both high in IDLE: the request is not accepted.
- start toggling during CALC is ignored. Operand changes during CALC are ignored because operands are latched.

Test Plan:
- Unsigned 100/7, sign=0 → stall high 33 cycles, done in cycle 33; q=14, r=2, div_zero=0.
- Signed -7/2 (0xFFFFFFF9/0x00000002), sign=1 → q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also check 7/-2 → q=-3, r=1.
- 0x12345678/0, signed and unsigned → q=0xFFFFFFFF, r=0x12345678, div_zero=1, done in cycle 33.
- Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0. Unsigned 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- cancel at cycle 10 of a 100/7 divide → IDLE next edge, no done, q/r keep their prior values. A new start next cycle completes correctly.
- rst asserted at cycle 20 → on the next edge all outputs are 0 and state is IDLE. start held high through DONE → exactly one done pulse, then a new division starts only if start is still high in IDLE.
